// File: rtl/conv_window_scheduler.sv
`timescale 1ns/1ps
// Frame sequencer for the stride-aligned KxK convolution window datapath:
// line-buffer addressing, window shift enables and output-pixel numbering.
module conv_window_scheduler #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int STRIDE  = 2,
    parameter int WIN_LAT = 2,
    parameter int ADDR_W  = 7,
    parameter int OUT_AW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_image,
    input  logic              pix_valid,
    output logic              accept_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              win_shift,
    output logic              win_valid,
    output logic [OUT_AW-1:0] out_addr,
    output logic              frame_done,
    output logic              busy
);
    localparam int OW    = (IMG_W - K) / STRIDE + 1;
    localparam int OH    = (IMG_H - K) / STRIDE + 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int DRN_W = $clog2(WIN_LAT + 1);

    localparam logic [OUT_AW-1:0] OUT_LAST  = OUT_AW'(OH * OW - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(K - 1);
    localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(K - 1);
    localparam logic [COL_W-1:0]  COL_STEP  = COL_W'(STRIDE);
    localparam logic [ROW_W-1:0]  ROW_STEP  = ROW_W'(STRIDE);

    // IDLE: wait for new_image | RUN: accept pixels | DRAIN: flush window pipe | DONE: frame_done
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} stateT;

    stateT              state;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   colOff;
    logic [ROW_W-1:0]   rowOff;
    logic [DRN_W-1:0]   drainCnt;
    logic [WIN_LAT-1:0] qualPipe;
    logic               accept;
    logic               qualify;
    logic               lastPix;
    logic               startFrame;

    assign accept     = pix_valid & accept_data;
    assign wr_en      = accept;
    assign wr_addr    = ADDR_W'(col);
    assign rd_addr    = ADDR_W'(col);
    assign colOff     = col - COL_FIRST;
    assign rowOff     = row - ROW_FIRST;
    assign qualify    = (col >= COL_FIRST) && (row >= ROW_FIRST) &&
                        ((colOff % COL_STEP) == '0) && ((rowOff % ROW_STEP) == '0);
    assign lastPix    = (col == COL_LAST) && (row == ROW_LAST);
    assign startFrame = new_image && ((state == IDLE) || (state == DONE));
    assign win_valid  = qualPipe[WIN_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            drainCnt    <= '0;
            qualPipe    <= '0;
            accept_data <= 1'b0;
            win_shift   <= 1'b0;
            out_addr    <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Qualify flags travel alongside the pixel so stalls never stretch a pulse.
            qualPipe   <= WIN_LAT'({qualPipe, accept & qualify});
            win_shift  <= accept;
            frame_done <= 1'b0;

            if (win_valid && (out_addr != OUT_LAST)) begin
                out_addr <= out_addr + 1'b1;
            end

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            unique case (state)
                IDLE: ;
                RUN: begin
                    if (accept && lastPix) begin
                        state       <= DRAIN;
                        accept_data <= 1'b0;
                        drainCnt    <= DRN_W'(WIN_LAT - 1);
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (startFrame) begin
                state       <= RUN;
                accept_data <= 1'b1;
                busy        <= 1'b1;
                col         <= '0;
                row         <= '0;
                out_addr    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conv_window_scheduler.sv
`timescale 1ns/1ps
// Bench: an 8x8 and a 7x7 scheduler share one pixel stream and are compared every cycle
// against a pixel-index reference model; a table of frame scenarios checks pulse/frame totals.
module tb_conv_window_scheduler;
    localparam int K       = 3;
    localparam int STRIDE  = 2;
    localparam int WIN_LAT = 2;
    localparam int ADDR_W  = 7;
    localparam int OUT_AW  = 4;
    localparam int LIMIT   = 1500;

    logic              clk = 1'b0;
    logic              reset;
    logic              pixValid;
    logic [1:0]        newImage;
    logic [1:0]        acceptData, wrEn, winShift, winValid, frameDone, busy;
    logic [ADDR_W-1:0] wrAddr [2];
    logic [ADDR_W-1:0] rdAddr [2];
    logic [OUT_AW-1:0] outAddr [2];

    always #5 clk = ~clk;

    conv_window_scheduler #(.IMG_W(8), .IMG_H(8), .K(K), .STRIDE(STRIDE), .WIN_LAT(WIN_LAT),
                            .ADDR_W(ADDR_W), .OUT_AW(OUT_AW)) dut8 (
        .clk(clk), .reset(reset), .new_image(newImage[0]), .pix_valid(pixValid),
        .accept_data(acceptData[0]), .wr_en(wrEn[0]), .wr_addr(wrAddr[0]), .rd_addr(rdAddr[0]),
        .win_shift(winShift[0]), .win_valid(winValid[0]), .out_addr(outAddr[0]),
        .frame_done(frameDone[0]), .busy(busy[0]));

    conv_window_scheduler #(.IMG_W(7), .IMG_H(7), .K(K), .STRIDE(STRIDE), .WIN_LAT(WIN_LAT),
                            .ADDR_W(ADDR_W), .OUT_AW(OUT_AW)) dut7 (
        .clk(clk), .reset(reset), .new_image(newImage[1]), .pix_valid(pixValid),
        .accept_data(acceptData[1]), .wr_en(wrEn[1]), .wr_addr(wrAddr[1]), .rd_addr(rdAddr[1]),
        .win_shift(winShift[1]), .win_valid(winValid[1]), .out_addr(outAddr[1]),
        .frame_done(frameDone[1]), .busy(busy[1]));

    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    function automatic int imgSide(int d);
        return (d == 0) ? 8 : 7;
    endfunction

    function automatic int numOut(int d);
        int o;
        o = (imgSide(d) - K) / STRIDE + 1;
        return o * o;
    endfunction

    function automatic bit qualifies(int d, int idx);
        int r, c;
        r = idx / imgSide(d);
        c = idx % imgSide(d);
        return (r >= K - 1) && (c >= K - 1) && ((r - (K - 1)) % STRIDE == 0) &&
               ((c - (K - 1)) % STRIDE == 0);
    endfunction

    // Reference model: frame progress expressed as accepted-pixel count and edge timestamps.
    bit inFrame [2];
    int pixN [2], cyc [2], doneEdge [2], outIdx [2], qHead [2], qTail [2];
    int dueT [2][16];
    bit expValid [2], expDone [2], expShift [2], expBusy [2];
    int expAddr [2];
    int pulseCnt [2], doneCnt [2];

    always @(posedge clk or negedge reset) begin : model
        bit acc;
        bit startOk;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                inFrame[d] = 0; pixN[d] = 0; cyc[d] = 0; doneEdge[d] = -10; outIdx[d] = 0;
                qHead[d] = 0; qTail[d] = 0; expValid[d] = 0; expDone[d] = 0;
                expShift[d] = 0; expBusy[d] = 0; expAddr[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                acc     = pixValid && inFrame[d];
                startOk = !inFrame[d] && (cyc[d] >= doneEdge[d]);
                cyc[d]++;
                expShift[d] = acc;
                expValid[d] = 0;
                expDone[d]  = (cyc[d] == doneEdge[d]);
                if (acc) begin
                    if (qualifies(d, pixN[d])) begin
                        dueT[d][qTail[d] % 16] = cyc[d] + WIN_LAT - 1;
                        qTail[d]++;
                    end
                    pixN[d]++;
                    if (pixN[d] == imgSide(d) * imgSide(d)) begin
                        inFrame[d]  = 0;
                        doneEdge[d] = cyc[d] + WIN_LAT;
                    end
                end
                if (qHead[d] < qTail[d] && dueT[d][qHead[d] % 16] == cyc[d]) begin
                    qHead[d]++;
                    expValid[d] = 1;
                    expAddr[d]  = (outIdx[d] < numOut(d) - 1) ? outIdx[d] : numOut(d) - 1;
                    outIdx[d]++;
                end
                if (newImage[d] && startOk) begin
                    inFrame[d] = 1;
                    pixN[d]    = 0;
                    outIdx[d]  = 0;
                end
                expBusy[d] = inFrame[d] || (cyc[d] < doneEdge[d]);
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                int wa;
                wa = inFrame[d] ? pixN[d] % imgSide(d) : 0;
                chk($sformatf("accept_data[%0d]@%0d", d, cyc[d]), acceptData[d], inFrame[d]);
                chk($sformatf("wr_en[%0d]@%0d", d, cyc[d]), wrEn[d], pixValid && inFrame[d]);
                chk($sformatf("wr_addr[%0d]@%0d", d, cyc[d]), wrAddr[d], wa);
                chk($sformatf("rd_addr[%0d]@%0d", d, cyc[d]), rdAddr[d], wa);
                chk($sformatf("win_shift[%0d]@%0d", d, cyc[d]), winShift[d], expShift[d]);
                chk($sformatf("win_valid[%0d]@%0d", d, cyc[d]), winValid[d], expValid[d]);
                chk($sformatf("frame_done[%0d]@%0d", d, cyc[d]), frameDone[d], expDone[d]);
                chk($sformatf("busy[%0d]@%0d", d, cyc[d]), busy[d], expBusy[d]);
                if (expValid[d])
                    chk($sformatf("out_addr[%0d]@%0d", d, cyc[d]), outAddr[d], expAddr[d]);
                if (winValid[d])  pulseCnt[d]++;
                if (frameDone[d]) doneCnt[d]++;
            end
        end
    end

    task automatic checkZero(string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s.accept_data[%0d]", tag, d), acceptData[d], 0);
            chk($sformatf("%s.wr_en[%0d]", tag, d), wrEn[d], 0);
            chk($sformatf("%s.wr_addr[%0d]", tag, d), wrAddr[d], 0);
            chk($sformatf("%s.win_shift[%0d]", tag, d), winShift[d], 0);
            chk($sformatf("%s.win_valid[%0d]", tag, d), winValid[d], 0);
            chk($sformatf("%s.out_addr[%0d]", tag, d), outAddr[d], 0);
            chk($sformatf("%s.frame_done[%0d]", tag, d), frameDone[d], 0);
            chk($sformatf("%s.busy[%0d]", tag, d), busy[d], 0);
        end
    endtask

    typedef struct {
        string name;
        int    gap;        // 0 continuous, 1 every 3rd cycle idle, 2 random
        int    reimageAt;  // pixel count at which new_image is re-pulsed (-1 none)
        int    resetAt;    // pixel count at which reset is asserted (-1 none)
        bit    b2b;        // restart each instance in its frame_done cycle
        int    expPulses8;
        int    expDone8;
        int    expPulses7;
        int    expDone7;
    } vecT;

    function automatic bit pickPix(int gap, int t);
        if (gap == 0) return 1'b1;
        if (gap == 1) return (t % 3) != 2;
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic runVec(input vecT v);
        int  budget;
        int  t;
        bit  aborted;
        bit  reimaged;
        bit [1:0] b2bUsed;
        pulseCnt = '{0, 0};
        doneCnt  = '{0, 0};
        aborted  = 0;
        reimaged = 0;
        b2bUsed  = 2'b00;
        t        = 0;
        @(posedge clk); #1;
        newImage = 2'b11;
        pixValid = pickPix(v.gap, t);
        for (budget = 0; budget < LIMIT; budget++) begin
            @(posedge clk); #1;
            t++;
            newImage = 2'b00;
            if (v.resetAt >= 0 && pixN[0] == v.resetAt) begin
                reset = 1'b0;
                #1;
                checkZero({v.name, ".abort"});
                @(negedge clk);
                reset   = 1'b1;
                aborted = 1;
                break;
            end
            if (v.resetAt < 0 && doneCnt[0] >= v.expDone8 && doneCnt[1] >= v.expDone7) break;
            if (v.reimageAt >= 0 && !reimaged && pixN[0] == v.reimageAt) begin
                newImage = 2'b11;
                reimaged = 1;
            end
            if (v.b2b) begin
                for (int d = 0; d < 2; d++) begin
                    if (frameDone[d] && !b2bUsed[d]) begin
                        newImage[d] = 1'b1;
                        b2bUsed[d]  = 1'b1;
                    end
                end
            end
            pixValid = pickPix(v.gap, t);
        end
        chk({v.name, ".timeout"}, int'(budget >= LIMIT), 0);
        repeat (4) begin
            @(posedge clk); #1;
            newImage = 2'b00;
            pixValid = pickPix(2, 0);
        end
        chk({v.name, ".aborted"}, aborted, int'(v.resetAt >= 0));
        chk({v.name, ".pulses8"}, pulseCnt[0], v.expPulses8);
        chk({v.name, ".frames8"}, doneCnt[0], v.expDone8);
        chk({v.name, ".pulses7"}, pulseCnt[1], v.expPulses7);
        chk({v.name, ".frames7"}, doneCnt[1], v.expDone7);
    endtask

    vecT vecs [6];

    initial begin
        vecs[0] = '{name:"cont",    gap:0, reimageAt:-1, resetAt:-1, b2b:0,
                    expPulses8:9,  expDone8:1, expPulses7:9,  expDone7:1};
        vecs[1] = '{name:"gap3",    gap:1, reimageAt:-1, resetAt:-1, b2b:0,
                    expPulses8:9,  expDone8:1, expPulses7:9,  expDone7:1};
        vecs[2] = '{name:"reimage", gap:2, reimageAt:30, resetAt:-1, b2b:0,
                    expPulses8:9,  expDone8:1, expPulses7:9,  expDone7:1};
        vecs[3] = '{name:"reset41", gap:0, reimageAt:-1, resetAt:41, b2b:0,
                    expPulses8:6,  expDone8:0, expPulses7:6,  expDone7:0};
        vecs[4] = '{name:"b2b",     gap:2, reimageAt:-1, resetAt:-1, b2b:1,
                    expPulses8:18, expDone8:2, expPulses7:18, expDone7:2};
        vecs[5] = '{name:"random",  gap:2, reimageAt:-1, resetAt:-1, b2b:0,
                    expPulses8:9,  expDone8:1, expPulses7:9,  expDone7:1};

        reset    = 1'b0;
        pixValid = 1'b0;
        newImage = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        checkZero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pixValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkZero("idle_no_start");

        for (int i = 0; i < 6; i++) runVec(vecs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
